id_ex_ctrl_stage: RTL and testbench

// - Pipeline ID->EX control producer: decodes the ID-stage instruction into main-control signals, ALUOp and the 4-bit funct the EX-stage ALU control consumes, then registers them in the ID/EX register.
// - Sign-extends immediates and detects load-use hazards, inserting a bubble.
// - Supports stall and flush from the hazard/branch unit.

---
 rtl/id_ex_ctrl_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_ctrl_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_stage.sv
// ID -> EX control producer. Decodes the ID-stage instruction into main
// control, ALUOp and the 4-bit funct field used by the EX-stage ALU control.
// It also sign-extends the immediate, detects load-use hazards, and holds the
// result in the ID/EX register. Stall and flush requests from the
// hazard/branch unit act on that register.
module id_ex_ctrl_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     id_instr,
    input  logic            id_valid,
    input  logic            stall,
    input  logic            flush,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_op,
    output logic [3:0]      ex_funct,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_illegal,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_imm
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic [1:0]      alu_op;
        logic [3:0]      funct;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            illegal;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
    } ctrl_t;

    ctrl_t       dec_p0;
    ctrl_t       ex_p1;
    logic        vld_p1;
    logic [6:0]  opcode;
    logic        uses_rs2;
    logic        load_use;

    // Every immediate format fits in 13 bits once the sign bit is replicated.
    function automatic logic signed [XLEN-1:0] sext13(input logic signed [12:0] v);
        return {{(XLEN-13){v[12]}}, v};
    endfunction

    assign opcode = id_instr[6:0];

    // Stage p0: combinational decode of the ID instruction
    always_comb begin
        dec_p0       = '0;
        uses_rs2     = 1'b0;
        dec_p0.funct = {id_instr[30], id_instr[14:12]};
        dec_p0.rs1   = id_instr[19:15];
        dec_p0.rs2   = id_instr[24:20];
        dec_p0.rd    = id_instr[11:7];
        case (opcode)
            OP_R: begin
                dec_p0.alu_op    = 2'b10;
                dec_p0.reg_write = 1'b1;
                uses_rs2         = 1'b1;
            end
            OP_LD: begin
                dec_p0.alu_op     = 2'b00;
                dec_p0.alu_src    = 1'b1;
                dec_p0.mem_read   = 1'b1;
                dec_p0.mem_to_reg = 1'b1;
                dec_p0.reg_write  = 1'b1;
                dec_p0.imm        = sext13({id_instr[31], id_instr[31:20]});
            end
            OP_SD: begin
                dec_p0.alu_op    = 2'b00;
                dec_p0.alu_src   = 1'b1;
                dec_p0.mem_write = 1'b1;
                dec_p0.imm       = sext13({id_instr[31], id_instr[31:25], id_instr[11:7]});
                uses_rs2         = 1'b1;
            end
            OP_BEQ: begin
                dec_p0.alu_op = 2'b01;
                dec_p0.branch = 1'b1;
                dec_p0.imm    = sext13({id_instr[31], id_instr[7], id_instr[30:25],
                                        id_instr[11:8], 1'b0});
                uses_rs2      = 1'b1;
            end
            default: dec_p0.illegal = 1'b1;
        endcase
    end

    // A load in EX whose rd feeds the ID instruction must be separated by a bubble.
    // rd=x0 never counts, and rs2 only counts for formats that actually read it.
    assign load_use = vld_p1 & ex_p1.mem_read & (ex_p1.rd != 5'd0) & id_valid &
                      ((ex_p1.rd == dec_p0.rs1) | ((ex_p1.rd == dec_p0.rs2) & uses_rs2));

    // A flush squashes the instruction, so no hold request is needed alongside it.
    assign load_use_stall = load_use & ~flush;

    // Stage p1: ID/EX register; flush beats stall, stall beats the load-use bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ex_p1  <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            ex_p1  <= '0;
        end else if (!stall) begin
            if (load_use || !id_valid) begin
                vld_p1 <= 1'b0;
                ex_p1  <= '0;
            end else begin
                vld_p1 <= 1'b1;
                ex_p1  <= dec_p0;
            end
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_alu_op     = ex_p1.alu_op;
    assign ex_funct      = ex_p1.funct;
    assign ex_alu_src    = ex_p1.alu_src;
    assign ex_reg_write  = ex_p1.reg_write;
    assign ex_mem_read   = ex_p1.mem_read;
    assign ex_mem_write  = ex_p1.mem_write;
    assign ex_mem_to_reg = ex_p1.mem_to_reg;
    assign ex_branch     = ex_p1.branch;
    assign ex_illegal    = ex_p1.illegal;
    assign ex_rs1        = ex_p1.rs1;
    assign ex_rs2        = ex_p1.rs2;
    assign ex_rd         = ex_p1.rd;
    assign ex_imm        = ex_p1.imm;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage. The stimulus applies one vector per
// cycle on the falling edge. With each vector it queues the hand-computed
// EX-register contents expected at that moment, plus the expected
// load_use_stall. A separate monitor pops each entry and compares it with the
// DUT shortly after the falling edge.
module tb_id_ex_ctrl_stage;

    localparam int XLEN = 64;

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic [3:0]  funct;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        illegal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
    } exp_t;

    typedef struct packed {
        logic [15:0] idx;
        exp_t        e;
        logic        lus;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     id_instr = '0;
    logic            id_valid = 1'b0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic            load_use_stall;
    logic            ex_valid;
    logic [1:0]      ex_alu_op;
    logic [3:0]      ex_funct;
    logic            ex_alu_src;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_branch;
    logic            ex_illegal;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_imm;

    rec_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_steps  = 0;

    id_ex_ctrl_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_imm(ex_imm)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [1:0] op, input logic [3:0] fn,
                                input logic src, input logic rw, input logic mr,
                                input logic mw, input logic m2r, input logic br,
                                input logic ill, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic [63:0] imm);
        exp_t e;
        e = '{valid: v, alu_op: op, funct: fn, alu_src: src, reg_write: rw,
              mem_read: mr, mem_write: mw, mem_to_reg: m2r, branch: br,
              illegal: ill, rs1: r1, rs2: r2, rd: rd, imm: imm};
        return e;
    endfunction

    // Instruction encodings
    localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h402081B3; // sub x3,x1,x2
    localparam logic [31:0] I_AND   = 32'h0020F1B3; // and x3,x1,x2
    localparam logic [31:0] I_LD    = 32'h0080B283; // ld x5,8(x1)
    localparam logic [31:0] I_LDN   = 32'hFF80B283; // ld x5,-8(x1)
    localparam logic [31:0] I_SD    = 32'h0020B823; // sd x2,16(x1)
    localparam logic [31:0] I_BEQ   = 32'h00000463; // beq x0,x0,8
    localparam logic [31:0] I_ADD6  = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] I_ILL   = 32'h00000013; // addi (unsupported)
    localparam logic [31:0] I_LD0   = 32'h0080B003; // ld x0,8(x1)
    localparam logic [31:0] I_ADDX0 = 32'h00100333; // add x6,x0,x1

    // Hand-computed EX contents for each instruction
    exp_t E_BUB, E_ADD, E_SUB, E_AND, E_LD, E_LDN, E_SD, E_BEQ, E_ADD6, E_ILL, E_LD0, E_ADDX0;

    task automatic step(input logic rn, input logic [31:0] ins, input logic v,
                        input logic st, input logic fl, input exp_t e, input logic lus);
        rec_t r;
        @(negedge clk);
        rst_n    = rn;
        id_instr = ins;
        id_valid = v;
        stall    = st;
        flush    = fl;
        n_steps++;
        r.idx = 16'(n_steps);
        r.e   = e;
        r.lus = lus;
        q.push_back(r);
    endtask

    // Monitor: compares queued expectations with the DUT just after each falling edge
    initial begin
        rec_t r;
        exp_t act;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                r   = q.pop_front();
                act = '{valid: ex_valid, alu_op: ex_alu_op, funct: ex_funct,
                        alu_src: ex_alu_src, reg_write: ex_reg_write,
                        mem_read: ex_mem_read, mem_write: ex_mem_write,
                        mem_to_reg: ex_mem_to_reg, branch: ex_branch,
                        illegal: ex_illegal, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
                        imm: ex_imm};
                n_checks++;
                if (act !== r.e) begin
                    n_fails++;
                    $display("FAIL ex_state step %0d: got %h required %h", r.idx, act, r.e);
                end
                n_checks++;
                if (load_use_stall !== r.lus) begin
                    n_fails++;
                    $display("FAIL load_use_stall step %0d: got %b required %b",
                             r.idx, load_use_stall, r.lus);
                end
            end
        end
    end

    initial begin
        int waited;
        E_BUB   = '0;
        E_ADD   = mk(1, 2'b10, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3, 64'd0);
        E_SUB   = mk(1, 2'b10, 4'h8, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3, 64'd0);
        E_AND   = mk(1, 2'b10, 4'h7, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3, 64'd0);
        E_LD    = mk(1, 2'b00, 4'h3, 1, 1, 1, 0, 1, 0, 0, 1, 8, 5, 64'd8);
        E_LDN   = mk(1, 2'b00, 4'hB, 1, 1, 1, 0, 1, 0, 0, 1, 24, 5, 64'hFFFF_FFFF_FFFF_FFF8);
        E_SD    = mk(1, 2'b00, 4'h3, 1, 0, 0, 1, 0, 0, 0, 1, 2, 16, 64'd16);
        E_BEQ   = mk(1, 2'b01, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 64'd8);
        E_ADD6  = mk(1, 2'b10, 4'h0, 0, 1, 0, 0, 0, 0, 0, 5, 1, 6, 64'd0);
        E_ILL   = mk(1, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0);
        E_LD0   = mk(1, 2'b00, 4'h3, 1, 1, 1, 0, 1, 0, 0, 1, 8, 0, 64'd8);
        E_ADDX0 = mk(1, 2'b10, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 64'd0);

        //    rn  instr    vld st fl  EX now   lus
        step(0, I_ADD,   1, 0, 0, E_BUB,   0); // held in reset
        step(1, I_ADD,   1, 0, 0, E_BUB,   0); // released, no edge yet
        step(1, I_SUB,   1, 0, 0, E_ADD,   0);
        step(1, I_AND,   1, 0, 0, E_SUB,   0);
        step(1, I_LD,    1, 0, 0, E_AND,   0);
        step(1, I_BEQ,   1, 0, 0, E_LD,    0); // beq reads x0 only
        step(1, I_SD,    1, 0, 0, E_BEQ,   0);
        step(1, I_LDN,   1, 0, 0, E_SD,    0);
        step(1, I_ILL,   1, 0, 0, E_LDN,   0);
        step(1, I_LD,    1, 0, 0, E_ILL,   0);
        step(1, I_ADD6,  1, 0, 0, E_LD,    1); // load-use on x5
        step(1, I_ADD6,  1, 0, 0, E_BUB,   0); // bubble in EX
        step(1, I_AND,   1, 1, 0, E_ADD6,  0); // stall 3 cycles
        step(1, I_AND,   1, 1, 0, E_ADD6,  0);
        step(1, I_AND,   1, 1, 0, E_ADD6,  0);
        step(1, I_AND,   1, 0, 0, E_ADD6,  0); // still frozen
        step(1, I_SUB,   1, 1, 1, E_AND,   0); // flush + stall
        step(1, I_LD,    1, 0, 0, E_BUB,   0);
        step(1, I_ADD6,  1, 1, 0, E_LD,    1); // stall + load-use
        step(1, I_ADD6,  1, 0, 1, E_LD,    0); // flush + load-use
        step(1, I_LD0,   1, 0, 0, E_BUB,   0);
        step(1, I_ADDX0, 1, 0, 0, E_LD0,   0); // rd=x0 never hazards
        step(1, I_ADD,   0, 0, 0, E_ADDX0, 0); // invalid ID -> bubble
        step(1, I_ADD,   1, 0, 0, E_BUB,   0);
        step(0, I_ADD,   1, 0, 0, E_BUB,   0); // async reset clears ADD
        step(1, I_SUB,   1, 0, 0, E_BUB,   0);
        step(1, I_ADD,   1, 0, 0, E_SUB,   0);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
